// File: rtl/lut_ff_mux_seq_pkg.sv
// Shared types and constants for the lut_ff_mux self-checking sequencer:
// FSM encoding, directed stimulus table and the LFSR step function.
package lut_ff_mux_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int          NUM_DIRECTED = 4;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // Each entry is {in[3:0], mux_sel}; entry 0 sits in the low bits.
  localparam logic [NUM_DIRECTED-1:0][4:0] DIRECTED_VECS = {
    5'b0001_1,
    5'b0001_0,
    5'b0100_1,
    5'b0100_0
  };

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lut_ff_mux_lfsr16.sv
// 16-bit Galois LFSR: reloads the seed on reset or load, steps on advance.
module lut_ff_mux_lfsr16
  import lut_ff_mux_seq_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/lut_ff_mux_seq_ctrl.sv
// Sequencer driving a golden lut_ff_mux and its netlist in lockstep: reset
// check, directed vectors, then LFSR vectors, counting Q disagreements.
module lut_ff_mux_seq_ctrl
  import lut_ff_mux_seq_pkg::*;
#(
  parameter int          RST_CYCLES    = 2,
  parameter int          SETTLE_CYCLES = 1,
  parameter int          CNT_W         = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_rand,
  output logic             dut_rst,
  output logic [3:0]       dut_in,
  output logic             dut_mux_sel,
  input  logic             q_golden,
  input  logic             q_netlist,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
);

  state_t           state;
  logic [3:0]       cyc_cnt;
  logic [CNT_W:0]   remaining;   // vectors still to apply after the current check
  logic [2:0]       dir_idx;
  logic [15:0]      lfsr_value;
  logic [15:0]      lfsr_next;
  logic             chk_fail;
  logic [CNT_W-1:0] mismatch_inc;
  logic             start_ok;
  logic             abort_ok;
  logic             more_vecs;
  logic             take_rand;

  // X or Z on either Q is a failure even when both sides agree on it.
  assign chk_fail = (q_golden !== q_netlist)
                 || (q_golden  !== 1'b0 && q_golden  !== 1'b1)
                 || (q_netlist !== 1'b0 && q_netlist !== 1'b1);

  assign mismatch_inc = (mismatch_cnt == '1) ? mismatch_cnt : mismatch_cnt + 1'b1;
  assign abort_ok     = abort && (state != S_IDLE);
  assign start_ok     = start && !abort && (state == S_IDLE || state == S_DONE);
  assign more_vecs    = (remaining != '0);
  assign take_rand    = (state == S_CHECK) && !abort && more_vecs
                     && (dir_idx == 3'(NUM_DIRECTED));
  assign lfsr_next    = lfsr_step(lfsr_value);

  lut_ff_mux_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok),
    .advance(take_rand),
    .value  (lfsr_value)
  );

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cyc_cnt      <= '0;
      remaining    <= '0;
      dir_idx      <= '0;
      dut_rst      <= 1'b1;
      dut_in       <= '0;
      dut_mux_sel  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      vec_cnt      <= '0;
      mismatch_cnt <= '0;
    end else if (abort_ok) begin
      state   <= S_IDLE;
      dut_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (start_ok) begin
      state        <= S_RST;
      cyc_cnt      <= 4'(RST_CYCLES - 1);
      remaining    <= {1'b0, num_rand} + (CNT_W+1)'(NUM_DIRECTED);
      dir_idx      <= '0;
      dut_rst      <= 1'b1;
      dut_in       <= '0;
      dut_mux_sel  <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      vec_cnt      <= '0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        S_RST: begin
          if (cyc_cnt == '0) state <= S_CHECK;
          else               cyc_cnt <= cyc_cnt - 1'b1;
        end
        S_APPLY: begin
          if (SETTLE_CYCLES == 0) begin
            state <= S_CHECK;
          end else begin
            state   <= S_SETTLE;
            cyc_cnt <= 4'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (cyc_cnt == '0) state <= S_CHECK;
          else               cyc_cnt <= cyc_cnt - 1'b1;
        end
        S_CHECK: begin
          vec_cnt <= vec_cnt + 1'b1;
          if (chk_fail) mismatch_cnt <= mismatch_inc;
          if (!more_vecs) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !chk_fail && (mismatch_cnt == '0);
          end else begin
            state     <= S_APPLY;
            remaining <= remaining - 1'b1;
            dut_rst   <= 1'b0;
            if (dir_idx < 3'(NUM_DIRECTED)) begin
              {dut_in, dut_mux_sel} <= DIRECTED_VECS[dir_idx[1:0]];
              dir_idx               <= dir_idx + 1'b1;
            end else begin
              {dut_in, dut_mux_sel} <= {lfsr_next[3:0], lfsr_next[4]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_ff_mux_seq_ctrl.sv
// Directed bench for lut_ff_mux_seq_ctrl: a default-parameter instance plus a
// narrow-counter instance for wrap and saturation behaviour.
module tb_lut_ff_mux_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start, abort;
  logic [15:0] num_rand;
  logic        q_golden, q_netlist;
  logic        dut_rst, dut_mux_sel, busy, done, pass;
  logic [3:0]  dut_in;
  logic [15:0] vec_cnt, mismatch_cnt;

  logic        start_b, abort_b;
  logic [3:0]  num_rand_b;
  logic        q_golden_b, q_netlist_b;
  logic        dut_rst_b, dut_mux_sel_b, busy_b, done_b, pass_b;
  logic [3:0]  dut_in_b;
  logic [3:0]  vec_cnt_b, mismatch_cnt_b;

  logic        inj_en, x_en, x_val;
  logic [15:0] inj_idx, x_idx;
  logic        model_q, inj_now, x_now;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cyc;

  logic [3:0] exp_in  [8] = '{4'h0, 4'h4, 4'h4, 4'h1, 4'h1, 4'h0, 4'h8, 4'hC};
  logic       exp_sel [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  // Stand-in for the lut_ff_mux pair; the netlist copy can be corrupted per check.
  assign model_q   = dut_mux_sel ? dut_in[3] : dut_in[2];
  assign inj_now   = inj_en && busy && (vec_cnt == inj_idx);
  assign x_now     = x_en && busy && (vec_cnt == x_idx);
  assign q_golden  = x_now ? ~x_val : model_q;
  assign q_netlist = x_now ? x_val : (inj_now ? ~model_q : model_q);

  assign q_golden_b  = ^{dut_rst_b, dut_in_b, dut_mux_sel_b};
  assign q_netlist_b = ~q_golden_b;

  lut_ff_mux_seq_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_rand    (num_rand),
    .dut_rst     (dut_rst),
    .dut_in      (dut_in),
    .dut_mux_sel (dut_mux_sel),
    .q_golden    (q_golden),
    .q_netlist   (q_netlist),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .vec_cnt     (vec_cnt),
    .mismatch_cnt(mismatch_cnt)
  );

  lut_ff_mux_seq_ctrl #(
    .RST_CYCLES   (1),
    .SETTLE_CYCLES(0),
    .CNT_W        (4)
  ) u_sat (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .abort       (abort_b),
    .num_rand    (num_rand_b),
    .dut_rst     (dut_rst_b),
    .dut_in      (dut_in_b),
    .dut_mux_sel (dut_mux_sel_b),
    .q_golden    (q_golden_b),
    .q_netlist   (q_netlist_b),
    .busy        (busy_b),
    .done        (done_b),
    .pass        (pass_b),
    .vec_cnt     (vec_cnt_b),
    .mismatch_cnt(mismatch_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] n);
    num_rand = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_start_b(input logic [3:0] n);
    num_rand_b = n;
    start_b    = 1'b1;
    @(negedge clk);
    start_b    = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int budget, output int n);
    n = 0;
    while (n < budget && !(sel_b ? done_b : done)) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at the negedge after the edge that applies vector k_lo.
  task automatic check_vectors(input int k_lo, input int k_hi);
    for (int k = k_lo; k <= k_hi; k++) begin
      check($sformatf("vec%0d_in", k),  dut_in,      exp_in[k]);
      check($sformatf("vec%0d_sel", k), dut_mux_sel, exp_sel[k]);
      if (k < k_hi) repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; num_rand = '0;
    start_b = 1'b0; abort_b = 1'b0; num_rand_b = '0;
    inj_en = 1'b0; x_en = 1'b0; inj_idx = '0; x_idx = '0;
    x_val = 1'bx;

    // Reset held, then idle without start.
    repeat (3) @(negedge clk);
    check("rst_dut_rst", dut_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_vec", vec_cnt, 0);
    check("rst_mism", mismatch_cnt, 0);
    check("rst_in", {dut_in, dut_mux_sel}, 0);
    check("rst_b_dut_rst", dut_rst_b, 1);
    check("rst_b_busy", busy_b, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_dut_rst", dut_rst, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_vec", vec_cnt, 0);
    check("idle_mism", mismatch_cnt, 0);

    // Directed only, matching Q: done 15 cycles after the start edge.
    pulse_start(16'd0);
    check("dir_busy", busy, 1);
    check("dir_dut_rst0", dut_rst, 1);
    check_vectors(0, 4);
    check("dir_dut_rst1", dut_rst, 0);
    repeat (2) @(negedge clk);
    check("dir_not_early", done, 0);
    @(negedge clk);
    check("dir_done", done, 1);
    check("dir_busy_end", busy, 0);
    check("dir_vec", vec_cnt, 5);
    check("dir_mism", mismatch_cnt, 0);
    check("dir_pass", pass, 1);
    repeat (2) @(negedge clk);
    check("dir_hold_done", done, 1);
    check("dir_hold_in", {dut_in, dut_mux_sel}, {4'h1, 1'b1});

    // 100 random vectors with one fault at check index 7; restarted from DONE.
    inj_en = 1'b1; inj_idx = 16'd7;
    pulse_start(16'd100);
    check("rnd_done_clr", done, 0);
    check("rnd_vec_clr", vec_cnt, 0);
    check("rnd_busy", busy, 1);
    repeat (15) @(negedge clk);
    check_vectors(5, 7);
    wait_done(1'b0, 400, n_cyc);
    check("rnd_done", done, 1);
    check("rnd_latency", n_cyc, 294);
    check("rnd_vec", vec_cnt, 105);
    check("rnd_mism", mismatch_cnt, 1);
    check("rnd_pass", pass, 0);
    inj_en = 1'b0;

    // Unknown Q on the netlist during the check of index 3.
    x_en = 1'b1; x_idx = 16'd3;
    pulse_start(16'd0);
    repeat (9) @(negedge clk);
    check("x_before", mismatch_cnt, 0);
    repeat (3) @(negedge clk);
    check("x_after", mismatch_cnt, 1);
    wait_done(1'b0, 50, n_cyc);
    check("x_done", done, 1);
    check("x_vec", vec_cnt, 5);
    check("x_mism", mismatch_cnt, 1);
    check("x_pass", pass, 0);
    x_en = 1'b0;

    // Abort in SETTLE of index 2.
    pulse_start(16'd3);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dut_rst", dut_rst, 1);
    check("abort_vec", vec_cnt, 2);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_sa_busy", busy, 0);
    check("idle_sa_vec", vec_cnt, 2);

    // Restart yields the same sequence, including the LFSR vectors.
    pulse_start(16'd3);
    check("rerun_vec_clr", vec_cnt, 0);
    check_vectors(0, 7);
    wait_done(1'b0, 50, n_cyc);
    check("rerun_latency", n_cyc, 3);
    check("rerun_vec", vec_cnt, 8);
    check("rerun_mism", mismatch_cnt, 0);
    check("rerun_pass", pass, 1);

    // start with abort in DONE: back to IDLE, counters held, no run.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("done_sa_done", done, 0);
    check("done_sa_pass", pass, 0);
    check("done_sa_dut_rst", dut_rst, 1);
    check("done_sa_vec", vec_cnt, 8);
    @(negedge clk);
    check("done_sa_busy", busy, 0);

    // Reset asserted in the middle of the index-3 CHECK.
    inj_en = 1'b1; inj_idx = 16'd1;
    pulse_start(16'd5);
    repeat (11) @(negedge clk);
    check("mid_vec_pre", vec_cnt, 3);
    check("mid_mism_pre", mismatch_cnt, 1);
    rst = 1'b0;
    #1;
    check("mid_vec", vec_cnt, 0);
    check("mid_mism", mismatch_cnt, 0);
    check("mid_dut_rst", dut_rst, 1);
    check("mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    inj_en = 1'b0;
    @(negedge clk);

    // Narrow counters, every check failing: saturation and wrap.
    pulse_start_b(4'd10);
    wait_done(1'b1, 100, n_cyc);
    check("sat10_done", done_b, 1);
    check("sat10_latency", n_cyc, 30);
    check("sat10_vec", vec_cnt_b, 15);
    check("sat10_mism", mismatch_cnt_b, 15);
    check("sat10_pass", pass_b, 0);
    pulse_start_b(4'd12);
    wait_done(1'b1, 100, n_cyc);
    check("sat12_done", done_b, 1);
    check("sat12_latency", n_cyc, 34);
    check("sat12_vec", vec_cnt_b, 1);
    check("sat12_mism", mismatch_cnt_b, 15);
    check("sat12_pass", pass_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
